// File: rtl/bounce_engine.sv
// Single square ball renderer for the VGA stream: moves once per FRAME_DIV frames,
// reflects off all four playfield edges and changes colour on every bounce.
module bounce_engine #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 8,
  parameter int SPEED_X   = 2,
  parameter int SPEED_Y   = 1,
  parameter int X_INIT    = 316,
  parameter int Y_INIT    = 236,
  parameter int FRAME_DIV = 1
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_HBlank,
  input  logic        i_VBlank,
  input  logic        i_HReset,
  input  logic        i_VReset,
  input  logic        i_Pause,
  output logic        o_Video,
  output logic [2:0]  o_Red,
  output logic [2:0]  o_Grn,
  output logic [2:0]  o_Blu,
  output logic        o_XDir,
  output logic        o_YDir,
  output logic        o_Bounce,
  output logic [15:0] o_BounceCount
);

  // One spare bit on each axis so position + speed + size can never wrap.
  localparam int XW = $clog2(H_ACTIVE) + 1;
  localparam int YW = $clog2(V_ACTIVE) + 1;
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [XW-1:0] X_SPD  = XW'(SPEED_X);
  localparam logic [XW-1:0] X_BALL = XW'(BALL_SIZE);
  localparam logic [XW-1:0] X_LIM  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE - BALL_SIZE);
  localparam logic [XW-1:0] X_RST  = XW'(X_INIT);
  localparam logic [YW-1:0] Y_SPD  = YW'(SPEED_Y);
  localparam logic [YW-1:0] Y_BALL = YW'(BALL_SIZE);
  localparam logic [YW-1:0] Y_LIM  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE - BALL_SIZE);
  localparam logic [YW-1:0] Y_RST  = YW'(Y_INIT);
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

  logic [XW-1:0] x_pos, x_next, col;
  logic [YW-1:0] y_pos, y_next, row;
  logic          x_dir_next, y_dir_next, x_refl, y_refl;
  logic          hblank_q, vblank_q;
  logic [DW-1:0] div_cnt;
  logic [2:0]    colour;
  logic [15:0]   bounce_cnt;
  logic          hit, frame_tick;

  assign hit = (col >= x_pos) && (col < x_pos + X_BALL) &&
               (row >= y_pos) && (row < y_pos + Y_BALL) &&
               !i_HBlank && !i_VBlank;

  // Motion only happens at the start of vertical blanking, so a frame never tears.
  assign frame_tick    = i_VBlank && !vblank_q;
  assign o_BounceCount = bounce_cnt;

  always_comb begin
    x_next     = x_pos;
    x_dir_next = o_XDir;
    x_refl     = 1'b0;
    if (o_XDir) begin
      if (x_pos + X_SPD + X_BALL > X_LIM) begin
        x_next     = X_MAX;
        x_dir_next = 1'b0;
        x_refl     = 1'b1;
      end else begin
        x_next = x_pos + X_SPD;
      end
    end else if (x_pos < X_SPD) begin
      x_next     = '0;
      x_dir_next = 1'b1;
      x_refl     = 1'b1;
    end else begin
      x_next = x_pos - X_SPD;
    end
  end

  always_comb begin
    y_next     = y_pos;
    y_dir_next = o_YDir;
    y_refl     = 1'b0;
    if (o_YDir) begin
      if (y_pos + Y_SPD + Y_BALL > Y_LIM) begin
        y_next     = Y_MAX;
        y_dir_next = 1'b0;
        y_refl     = 1'b1;
      end else begin
        y_next = y_pos + Y_SPD;
      end
    end else if (y_pos < Y_SPD) begin
      y_next     = '0;
      y_dir_next = 1'b1;
      y_refl     = 1'b1;
    end else begin
      y_next = y_pos - Y_SPD;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      x_pos      <= X_RST;
      y_pos      <= Y_RST;
      o_XDir     <= 1'b1;
      o_YDir     <= 1'b1;
      colour     <= 3'd7;
      bounce_cnt <= 16'd0;
      div_cnt    <= '0;
      col        <= '0;
      row        <= '0;
      hblank_q   <= 1'b1;
      vblank_q   <= 1'b1;
      o_Video    <= 1'b0;
      o_Red      <= 3'd0;
      o_Grn      <= 3'd0;
      o_Blu      <= 3'd0;
      o_Bounce   <= 1'b0;
    end else begin
      hblank_q <= i_HBlank;
      vblank_q <= i_VBlank;

      if (i_HReset)
        col <= '0;
      else if (!i_HBlank)
        col <= col + XW'(1);

      if (i_VReset)
        row <= '0;
      else if (i_HBlank && !hblank_q && !i_VBlank)
        row <= row + YW'(1);

      o_Video <= hit;
      o_Red   <= hit ? {3{colour[2]}} : 3'd0;
      o_Grn   <= hit ? {3{colour[1]}} : 3'd0;
      o_Blu   <= hit ? {3{colour[0]}} : 3'd0;

      o_Bounce <= 1'b0;
      if (frame_tick && !i_Pause) begin
        if (div_cnt != DIV_LAST) begin
          div_cnt <= div_cnt + DW'(1);
        end else begin
          div_cnt <= '0;
          x_pos   <= x_next;
          y_pos   <= y_next;
          o_XDir  <= x_dir_next;
          o_YDir  <= y_dir_next;
          // Colour cycles 1..7 and skips 0 so the ball is never drawn black.
          if (x_refl || y_refl) begin
            o_Bounce <= 1'b1;
            if (bounce_cnt != 16'hFFFF)
              bounce_cnt <= bounce_cnt + 16'd1;
            colour <= (colour == 3'd7) ? 3'd1 : colour + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bounce_engine.sv
// Directed bench for bounce_engine: five instances with different parameters,
// each held in reset until its own scenario runs.
module tb_bounce_engine;

  logic        clk = 1'b0;
  logic [4:0]  rst_n = 5'h1F;
  logic        hblank = 1'b1, vblank = 1'b1, hreset = 1'b0, vreset = 1'b0, pause = 1'b0;
  logic        video  [5];
  logic [2:0]  red    [5];
  logic [2:0]  grn    [5];
  logic [2:0]  blu    [5];
  logic        xdir   [5];
  logic        ydir   [5];
  logic        bounce [5];
  logic [15:0] bcount [5];

  int          vectors = 0;
  int          miscompares = 0;
  int          cnt, first;
  logic        rgb_bad;
  int          d_exp [9] = '{316, 316, 318, 318, 318, 318, 318, 320, 320};

  always #5 clk = ~clk;

  bounce_engine dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n[0]), .i_HBlank(hblank), .i_VBlank(vblank),
    .i_HReset(hreset), .i_VReset(vreset), .i_Pause(pause),
    .o_Video(video[0]), .o_Red(red[0]), .o_Grn(grn[0]), .o_Blu(blu[0]),
    .o_XDir(xdir[0]), .o_YDir(ydir[0]), .o_Bounce(bounce[0]), .o_BounceCount(bcount[0])
  );

  bounce_engine #(.X_INIT(628), .Y_INIT(100)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n[1]), .i_HBlank(hblank), .i_VBlank(vblank),
    .i_HReset(hreset), .i_VReset(vreset), .i_Pause(pause),
    .o_Video(video[1]), .o_Red(red[1]), .o_Grn(grn[1]), .o_Blu(blu[1]),
    .o_XDir(xdir[1]), .o_YDir(ydir[1]), .o_Bounce(bounce[1]), .o_BounceCount(bcount[1])
  );

  bounce_engine #(.X_INIT(632), .Y_INIT(472)) dut_c (
    .i_Clk(clk), .i_Rst_L(rst_n[2]), .i_HBlank(hblank), .i_VBlank(vblank),
    .i_HReset(hreset), .i_VReset(vreset), .i_Pause(pause),
    .o_Video(video[2]), .o_Red(red[2]), .o_Grn(grn[2]), .o_Blu(blu[2]),
    .o_XDir(xdir[2]), .o_YDir(ydir[2]), .o_Bounce(bounce[2]), .o_BounceCount(bcount[2])
  );

  bounce_engine #(.FRAME_DIV(3)) dut_d (
    .i_Clk(clk), .i_Rst_L(rst_n[3]), .i_HBlank(hblank), .i_VBlank(vblank),
    .i_HReset(hreset), .i_VReset(vreset), .i_Pause(pause),
    .o_Video(video[3]), .o_Red(red[3]), .o_Grn(grn[3]), .o_Blu(blu[3]),
    .o_XDir(xdir[3]), .o_YDir(ydir[3]), .o_Bounce(bounce[3]), .o_BounceCount(bcount[3])
  );

  // Tiny playfield where every single update reflects on both axes.
  bounce_engine #(.H_ACTIVE(16), .V_ACTIVE(16), .SPEED_X(9), .SPEED_Y(9),
                  .X_INIT(8), .Y_INIT(8)) dut_e (
    .i_Clk(clk), .i_Rst_L(rst_n[4]), .i_HBlank(hblank), .i_VBlank(vblank),
    .i_HReset(hreset), .i_VReset(vreset), .i_Pause(pause),
    .o_Video(video[4]), .o_Red(red[4]), .o_Grn(grn[4]), .o_Blu(blu[4]),
    .o_XDir(xdir[4]), .o_YDir(ydir[4]), .o_Bounce(bounce[4]), .o_BounceCount(bcount[4])
  );

  task automatic applyStimulus(input logic hb, input logic vb, input logic hr, input logic vr);
    hblank = hb;
    vblank = vb;
    hreset = hr;
    vreset = vr;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic vblank_edge();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // After each active cycle's negedge the video output reflects that cycle's pixel.
  task automatic run_line(input int sel, input int active, input logic [8:0] exp_rgb);
    cnt = 0;
    first = -1;
    rgb_bad = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < active; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (video[sel]) begin
        cnt++;
        if (first < 0) first = j;
        if ({red[sel], grn[sel], blu[sel]} !== exp_rgb) rgb_bad = 1'b1;
      end else if ({red[sel], grn[sel], blu[sel]} !== 9'd0) begin
        rgb_bad = 1'b1;
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic begin_frame(input int sel, input int short_lines);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (short_lines) run_line(sel, 1, 9'd0);
  endtask

  initial begin
    #1 rst_n = 5'h00;
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset state");
    checkOutput("rst_video", 32'(video[0]), 32'd0);
    checkOutput("rst_rgb", 32'({red[0], grn[0], blu[0]}), 32'd0);
    checkOutput("rst_xdir", 32'(xdir[0]), 32'd1);
    checkOutput("rst_ydir", 32'(ydir[0]), 32'd1);
    checkOutput("rst_bounce", 32'(bounce[0]), 32'd0);
    checkOutput("rst_count", 32'(bcount[0]), 32'd0);
    checkOutput("rst_x", 32'(dut_a.x_pos), 32'd316);
    checkOutput("rst_y", 32'(dut_a.y_pos), 32'd236);

    $display("[TB] render first frame");
    rst_n[0] = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    begin_frame(0, 236);
    for (int r = 0; r < 8; r++) begin
      run_line(0, 330, 9'h1FF);
      checkOutput($sformatf("a_row%0d_count", 236 + r), 32'(cnt), 32'd8);
      checkOutput($sformatf("a_row%0d_first", 236 + r), 32'(first), 32'd316);
      checkOutput($sformatf("a_row%0d_rgb", 236 + r), 32'(rgb_bad), 32'd0);
    end
    run_line(0, 330, 9'h1FF);
    checkOutput("a_row244_count", 32'(cnt), 32'd0);
    vblank_edge();
    checkOutput("a_move_x", 32'(dut_a.x_pos), 32'd318);
    checkOutput("a_move_y", 32'(dut_a.y_pos), 32'd237);
    checkOutput("a_move_bounce", 32'(bounce[0]), 32'd0);

    $display("[TB] asynchronous reset mid-line");
    begin_frame(0, 237);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (321) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("a_prereset_video", 32'(video[0]), 32'd1);
    rst_n[0] = 1'b0;
    #1;
    checkOutput("a_async_video", 32'(video[0]), 32'd0);
    checkOutput("a_async_rgb", 32'({red[0], grn[0], blu[0]}), 32'd0);
    checkOutput("a_async_x", 32'(dut_a.x_pos), 32'd316);
    checkOutput("a_async_y", 32'(dut_a.y_pos), 32'd236);
    checkOutput("a_async_dirs", 32'({xdir[0], ydir[0]}), 32'd3);

    $display("[TB] right wall");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n[1] = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    vblank_edge();
    checkOutput("b_upd1_x", 32'(dut_b.x_pos), 32'd630);
    checkOutput("b_upd1_bounce", 32'(bounce[1]), 32'd0);
    vblank_edge();
    checkOutput("b_upd2_x", 32'(dut_b.x_pos), 32'd632);
    checkOutput("b_upd2_xdir", 32'(xdir[1]), 32'd1);
    vblank_edge();
    checkOutput("b_upd3_x", 32'(dut_b.x_pos), 32'd632);
    checkOutput("b_upd3_xdir", 32'(xdir[1]), 32'd0);
    checkOutput("b_upd3_ydir", 32'(ydir[1]), 32'd1);
    checkOutput("b_upd3_y", 32'(dut_b.y_pos), 32'd103);
    checkOutput("b_upd3_bounce", 32'(bounce[1]), 32'd1);
    checkOutput("b_upd3_count", 32'(bcount[1]), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("b_bounce_single", 32'(bounce[1]), 32'd0);
    begin_frame(1, 103);
    run_line(1, 640, 9'h007);
    checkOutput("b_row103_count", 32'(cnt), 32'd8);
    checkOutput("b_row103_first", 32'(first), 32'd632);
    checkOutput("b_row103_rgb", 32'(rgb_bad), 32'd0);

    $display("[TB] left wall");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("b_left1_x", 32'(dut_b.x_pos), 32'd630);
    repeat (315) vblank_edge();
    checkOutput("b_left316_x", 32'(dut_b.x_pos), 32'd0);
    checkOutput("b_left316_xdir", 32'(xdir[1]), 32'd0);
    checkOutput("b_left316_count", 32'(bcount[1]), 32'd1);
    vblank_edge();
    checkOutput("b_leftrefl_x", 32'(dut_b.x_pos), 32'd0);
    checkOutput("b_leftrefl_xdir", 32'(xdir[1]), 32'd1);
    checkOutput("b_leftrefl_bounce", 32'(bounce[1]), 32'd1);
    checkOutput("b_leftrefl_count", 32'(bcount[1]), 32'd2);
    checkOutput("b_leftrefl_colour", 32'(dut_b.colour), 32'd2);
    checkOutput("b_leftrefl_y", 32'(dut_b.y_pos), 32'd420);
    rst_n[1] = 1'b0;

    $display("[TB] corner");
    rst_n[2] = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    vblank_edge();
    checkOutput("c_x", 32'(dut_c.x_pos), 32'd632);
    checkOutput("c_y", 32'(dut_c.y_pos), 32'd472);
    checkOutput("c_dirs", 32'({xdir[2], ydir[2]}), 32'd0);
    checkOutput("c_bounce", 32'(bounce[2]), 32'd1);
    checkOutput("c_count", 32'(bcount[2]), 32'd1);
    checkOutput("c_colour", 32'(dut_c.colour), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("c_bounce_single", 32'(bounce[2]), 32'd0);
    checkOutput("c_count_hold", 32'(bcount[2]), 32'd1);
    rst_n[2] = 1'b0;

    $display("[TB] frame divider and pause");
    rst_n[3] = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      pause = (e == 4 || e == 5);
      vblank_edge();
      checkOutput($sformatf("d_edge%0d_x", e), 32'(dut_d.x_pos), 32'(d_exp[e-1]));
    end
    pause = 1'b0;
    rst_n[3] = 1'b0;

    $display("[TB] counter saturation");
    rst_n[4] = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    vblank_edge();
    checkOutput("e_upd1_x", 32'(dut_e.x_pos), 32'd8);
    checkOutput("e_upd1_xdir", 32'(xdir[4]), 32'd0);
    checkOutput("e_upd1_count", 32'(bcount[4]), 32'd1);
    checkOutput("e_upd1_colour", 32'(dut_e.colour), 32'd1);
    force dut_e.bounce_cnt = 16'hFFFF;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    release dut_e.bounce_cnt;
    vblank_edge();
    checkOutput("e_sat_count", 32'(bcount[4]), 32'hFFFF);
    checkOutput("e_sat_bounce", 32'(bounce[4]), 32'd1);
    checkOutput("e_sat_colour", 32'(dut_e.colour), 32'd2);
    checkOutput("e_sat_x", 32'(dut_e.x_pos), 32'd0);
    checkOutput("e_sat_xdir", 32'(xdir[4]), 32'd1);
    rst_n[4] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bounce_engine.md
Name: bounce_engine

Overview:
- Parametrised successor to the fixed single-ball generator and horizontal hit detector.
- Renders one square ball into the VGA video stream from the timing generator's blank/reset strobes.
- Moves the ball once per N frames on both axes and reflects it off all four playfield edges.
- Drives 9-bit colour that changes on every bounce, plus bounce status for the rest of the game.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
BALL_SIZE, 8, ball edge length in pixels
SPEED_X, 2, pixels moved per update, horizontal
SPEED_Y, 1, pixels moved per update, vertical
X_INIT, 316, reset column of ball left edge
Y_INIT, 236, reset row of ball top edge
FRAME_DIV, 1, frames per position update (>=1)

Ports:
i_Clk  in  1  pixel clock
i_Rst_L  in  1  asynchronous active-low reset
i_HBlank  in  1  horizontal blanking
i_VBlank  in  1  vertical blanking
i_HReset  in  1  one-cycle pulse, start of line
i_VReset  in  1  one-cycle pulse, start of frame
i_Pause  in  1  freeze motion
o_Video  out  1  ball pixel active
o_Red  out  3  red, gated by o_Video
o_Grn  out  3  green, gated by o_Video
o_Blu  out  3  blue, gated by o_Video
o_XDir  out  1  1 = moving right
o_YDir  out  1  1 = moving down
o_Bounce  out  1  one-cycle pulse per update that reflected
o_BounceCount  out  16  saturating bounce counter

Behaviour:
- Reset (async, i_Rst_L=0): X=X_INIT, Y=Y_INIT, o_XDir=1, o_YDir=1, colour index=7, o_BounceCount=0, frame divider=0, col/row=0. o_Video, o_Bounce, o_Red, o_Grn and o_Blu are all 0.
- Column counter:
  - cleared by i_HReset.
  - otherwise increments each cycle with i_HBlank=0.
- Row counter:
  - cleared by i_VReset.
  - increments on the 0->1 edge of i_HBlank while i_VBlank=0.
  - i_VReset wins over the increment.
- Pixel test: hit = (X <= col < X+BALL_SIZE) && (Y <= row < Y+BALL_SIZE) && !i_HBlank && !i_VBlank.
- o_Video is hit registered, giving 1-cycle latency from the pixel's cycle.
- Colour index c[2:0] drives o_Red={3{c[2]}}, o_Grn={3{c[1]}}, o_Blu={3{c[0]}}. All three are registered with o_Video and forced to 0 when o_Video=0.
- Update event is the 0->1 edge of i_VBlank (no mid-frame tearing).
  - If i_Pause=1: no change; divider holds.
  - Else if divider != FRAME_DIV-1: divider++.
  - Else: divider=0 and both axes update in the same cycle.
- Axis update, horizontal (vertical identical with Y, SPEED_Y, V_ACTIVE, o_YDir):
  - Moving right: if X+SPEED_X+BALL_SIZE > H_ACTIVE then X=H_ACTIVE-BALL_SIZE and o_XDir=0 (reflect); else X+=SPEED_X.
  - Moving left: if X < SPEED_X then X=0 and o_XDir=1 (reflect); else X-=SPEED_X.
- Width rules:
  - Position registers are $clog2(H_ACTIVE)+1 and $clog2(V_ACTIVE)+1 bits, so the sum never wraps.
  - Comparisons are unsigned.
- Reflection on either or both axes in one update:
  - o_Bounce pulses exactly once, the cycle after the update.
  - o_BounceCount increments by 1, saturating at 16'hFFFF.
  - Colour index advances 7->1->2->...->7, never 0 (black).
- Reset asserted mid-frame or mid-update: all state returns to reset values immediately. Rendering resumes at the next i_HReset/i_VReset.

Test Plan:
- Reset: drop i_Rst_L mid-line with o_Video=1 -> o_Video=0, RGB=0, X=316, Y=236, o_XDir=o_YDir=1 with no clock edge. Release and render a frame -> o_Video high for col 316..323, rows 236..243 (64 pixels), each 1 cycle after its pixel, RGB=3'b111 each.
- Right wall: X_INIT=628, Y_INIT=100 -> updates give X=630, 632, then 632 with o_XDir=0. o_Bounce is a single 1-cycle pulse, o_BounceCount=1, o_Red=0, o_Grn=0, o_Blu=3'b111 on ball pixels.
- Corner: X_INIT=632, Y_INIT=472 -> first update X=632, Y=472, both dirs 0. Exactly one o_Bounce pulse, count=1, colour 7->1.
- Left wall: after the right-wall flip, force X to 1 moving left -> next update X=0, o_XDir=1, count increments, colour 1->2.
- Divider/pause: FRAME_DIV=3 -> X changes only on VBlank edges 3, 6, 9. i_Pause=1 across edges 4-5 -> X unchanged and next move on edge 8.
- Saturation: preload o_BounceCount=16'hFFFF (force) and trigger a bounce -> stays 16'hFFFF; o_Bounce still pulses and colour still advances.
